// File: rtl/if_fetch_queue.sv
// Fetch stage queue: issues imem requests at PC_F, buffers in-order responses for decode, drops wrong-path data.
// Define FETCH_BYPASS_EN to forward a response straight to decode when it belongs to the only queued fetch.
module if_fetch_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_F,
    input  logic        PC_src,
    input  logic        stall_D,
    output logic [31:0] PC_Plus4,
    output logic        stall_F,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_D,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_Plus4_D
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    head_q, tail_q, fill_q;
    logic [CW-1:0]    used_q, pend_q, drop_q;

    logic        credit, issue, rsp_drop, rsp_fill, flush_eat;
    logic        head_ready, bypass, deq;
    logic [31:0] head_instr;

    // In-flight wrong-path responses still occupy memory slots, so they hold credit too.
    assign credit    = (32'(used_q) + 32'(drop_q)) < DEPTH;
    assign imem_req  = !rst && !PC_src && credit;
    assign imem_addr = PC_F;
    assign PC_Plus4  = PC_F + 32'd4;
    assign issue     = imem_req && imem_gnt;
    assign stall_F   = !issue && !PC_src;

    assign rsp_drop   = imem_rvalid && (drop_q != '0);
    assign rsp_fill   = imem_rvalid && (drop_q == '0) && (pend_q != '0);
    assign flush_eat  = imem_rvalid && ((drop_q != '0) || (pend_q != '0));
    assign head_ready = (used_q != '0) && filled_q[head_q];

`ifdef FETCH_BYPASS_EN
    assign bypass     = rsp_fill && (used_q == CW'(1)) && !filled_q[head_q];
    assign head_instr = bypass ? imem_rdata : instr_q[head_q];
`else
    assign bypass     = 1'b0;
    assign head_instr = instr_q[head_q];
`endif

    assign valid_D    = head_ready || bypass;
    assign deq        = valid_D && !stall_D && !PC_src;
    assign instr_D    = valid_D ? head_instr : NOP_INSTR;
    assign PC_D       = valid_D ? pc_q[head_q] : 32'd0;
    assign PC_Plus4_D = PC_D + 32'd4;

    // fill_q tracks the oldest unfilled entry; responses arrive in issue order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            used_q   <= '0;
            pend_q   <= '0;
            drop_q   <= '0;
            filled_q <= '0;
        end else if (PC_src) begin
            head_q   <= tail_q;
            fill_q   <= tail_q;
            used_q   <= '0;
            pend_q   <= '0;
            filled_q <= '0;
            drop_q   <= drop_q + pend_q - CW'(flush_eat);
        end else begin
            if (issue) begin
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + PW'(1);
            end
            if (rsp_fill) begin
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PW'(1);
            end
            if (rsp_drop) begin
                drop_q <= drop_q - CW'(1);
            end
            if (deq) begin
                head_q <= head_q + PW'(1);
            end
            used_q <= used_q + CW'(issue) - CW'(deq);
            pend_q <= pend_q + CW'(issue) - CW'(rsp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_q[tail_q] <= PC_F;
        end
        if (rsp_fill) begin
            instr_q[fill_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a model PC register and 1-cycle memory drive the DUT;
// accepted fetch PCs are queued as expected decode outputs and retired when decode takes them.
module tb_if_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, PC_src, stall_D, imem_gnt, imem_rvalid;
    logic [31:0] PC_F, imem_rdata;
    logic [31:0] PC_Plus4, imem_addr, instr_D, PC_D, PC_Plus4_D;
    logic        stall_F, imem_req, valid_D;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] expQ[$];
    logic [31:0] memQ[$];
    logic [31:0] tbPc;
    logic        memHold;
    int          deqCount;
    logic        sReq, sStallF, sValid;
    logic [31:0] sPcD, sInstr;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(2), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .PC_F       (PC_F),
        .PC_src     (PC_src),
        .stall_D    (stall_D),
        .PC_Plus4   (PC_Plus4),
        .stall_F    (stall_F),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .valid_D    (valid_D),
        .instr_D    (instr_D),
        .PC_D       (PC_D),
        .PC_Plus4_D (PC_Plus4_D)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle, update scoreboard and PC model.
    task automatic applyStimulus(input logic src, input logic [31:0] target,
                                 input logic stall, input logic gnt);
        logic        take;
        logic [31:0] popped;
        PC_src   = src;
        stall_D  = stall;
        imem_gnt = gnt;
        PC_F     = tbPc;
        if (!memHold && memQ.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(memQ.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        sReq    = imem_req;
        sStallF = stall_F;
        sValid  = valid_D;
        sPcD    = PC_D;
        sInstr  = instr_D;
        checkOutput("imem_addr", imem_addr, tbPc);
        checkOutput("PC_Plus4", PC_Plus4, tbPc + 32'd4);
        if (rst || src) checkOutput("req_blocked", 32'(imem_req), 32'd0);
        if (rst) checkOutput("stall_F_rst", 32'(stall_F), 32'd1);
        if (src) checkOutput("stall_F_redirect", 32'(stall_F), 32'd0);
        if (expQ.size() == 0) checkOutput("valid_D_idle", 32'(valid_D), 32'd0);
        if (valid_D && expQ.size() > 0) begin
            checkOutput("PC_D", PC_D, expQ[0]);
            checkOutput("instr_D", instr_D, memWord(expQ[0]));
            checkOutput("PC_Plus4_D", PC_Plus4_D, expQ[0] + 32'd4);
        end else if (!valid_D) begin
            checkOutput("instr_D_nop", instr_D, NOP);
            checkOutput("PC_D_zero", PC_D, 32'd0);
            checkOutput("PC_Plus4_D_four", PC_Plus4_D, 32'd4);
        end
        take = valid_D && !stall && !src && !rst;
        if (take && expQ.size() > 0) begin
            popped = expQ.pop_front();
            deqCount++;
        end
        if (imem_req && gnt) begin
            expQ.push_back(tbPc);
            memQ.push_back(tbPc);
            tbPc = tbPc + 32'd4;
        end
        if (src || rst) expQ.delete();
        if (src) tbPc = target;
        @(posedge clk);
        #1;
    endtask

    task automatic drainQueue(input string tag);
        for (int i = 0; i < 30 && (expQ.size() > 0 || memQ.size() > 0); i++)
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          winStart;
        bit          seen;
        logic [31:0] firstPc;
        rst = 1'b1; PC_src = 1'b0; stall_D = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; PC_F = 32'd0;
        tbPc = 32'd0; memHold = 1'b0; deqCount = 0; winStart = 0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        rst = 1'b0;

        $display("[TB] sequential stream");
        for (int i = 0; i < 24; i++) begin
            if (i == 3) winStart = deqCount;
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
`ifdef FETCH_BYPASS_EN
            if (i >= 3) checkOutput("stall_F_stream", 32'(sStallF), 32'd0);
`endif
        end
        checkOutput("stream_rate", 32'(deqCount - winStart), BYP ? 32'd21 : 32'd14);

        $display("[TB] back-pressure");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("bp_req", 32'(sReq), 32'd0);
        checkOutput("bp_stall_F", 32'(sStallF), 32'd1);
        checkOutput("bp_valid", 32'(sValid), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        drainQueue("drain_bp");

        $display("[TB] redirect with two outstanding");
        memHold = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        memHold = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("redir_drop_credit", 32'(sReq), 32'd0);
        seen = 1'b0;
        firstPc = 32'd0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
            if (!seen && sValid) begin
                seen = 1'b1;
                firstPc = sPcD;
            end
        end
        checkOutput("redir_first_pc", firstPc, 32'h100);
        drainQueue("drain_redir");

        $display("[TB] redirect coinciding with response");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("flush_rsp_req", 32'(sReq), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        drainQueue("drain_flush_rsp");

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("rst_valid", 32'(sValid), 32'd0);
        checkOutput("rst_instr", sInstr, NOP);

        $display("[TB] fetch latency");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("lat_resp_cycle", 32'(sValid), BYP ? 32'd1 : 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("lat_next_cycle", 32'(sValid), BYP ? 32'd0 : 32'd1);
        drainQueue("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
